parallel_to_serial_lanes: RTL

Parametrised parallel-to-serial converter: accepts `width`-bit words on a valid/ready handshake and emits them as `width/lanes` beats of `lanes` bits each, with downstream backpressure, per-word bit-order selection and a last-beat marker. It sits between word-oriented datapath logic and narrow serial links (1-, 2- or 4-lane) in sequential-basics designs. It supersedes the single-lane, busy-throttled converter: upstream no longer polls `busy` and words stream back-to-back with no bubbles.

---
 rtl/parallel_to_serial_lanes.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/parallel_to_serial_lanes.sv
// Valid/ready word-to-beat serialiser: each width-bit word leaves as width/lanes beats of lanes bits.
// Define PARALLEL_TO_SERIAL_LANES_SKID_EN to add a one-word pending register with registered parallel_ready.
module parallel_to_serial_lanes #(
   parameter int width = 8,
   parameter int lanes = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             parallel_valid,
   output logic             parallel_ready,
   input  logic [width-1:0] parallel_data,
   input  logic             msb_first,
   output logic             serial_valid,
   input  logic             serial_ready,
   output logic [lanes-1:0] serial_data,
   output logic             serial_last,
   output logic             busy
);
   localparam int beats = width / lanes;
   localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
   localparam logic [cnt_w-1:0] last_cnt = cnt_w'(beats - 1);

   if (width % lanes != 0) begin : g_bad_cfg
      $fatal(1, "parallel_to_serial_lanes: width must be a multiple of lanes");
   end

   logic [width-1:0] shift_reg, shift_next;
   logic [lanes-1:0] data_reg, data_next;
   logic [cnt_w-1:0] cnt_reg, cnt_next;
   logic             mode_reg, mode_next;
   logic             active_reg, active_next;
   logic             load_en, load_msb;
   logic [width-1:0] load_word;
   logic             beat_xfer, final_xfer, word_xfer;

   // data_reg holds the beat on the wire; shift_reg holds the beats still to come.
   function automatic logic [lanes-1:0] head(input logic [width-1:0] w, input logic msb);
      return msb ? w[width-1 -: lanes] : w[lanes-1:0];
   endfunction

   function automatic logic [width-1:0] tail(input logic [width-1:0] w, input logic msb);
      return msb ? (w << lanes) : (w >> lanes);
   endfunction

   assign beat_xfer  = active_reg & serial_ready;
   assign final_xfer = beat_xfer & (cnt_reg == last_cnt);
   assign word_xfer  = parallel_valid & parallel_ready;

   assign serial_valid = active_reg;
   assign serial_data  = data_reg;
   assign serial_last  = active_reg & (cnt_reg == last_cnt);

`ifdef PARALLEL_TO_SERIAL_LANES_SKID_EN
   logic             pend_full_reg, pend_full_next;
   logic [width-1:0] pend_data_reg, pend_data_next;
   logic             pend_msb_reg, pend_msb_next;

   assign parallel_ready = ~pend_full_reg;
   assign busy           = active_reg | pend_full_reg;
`else
   assign parallel_ready = ~active_reg | (serial_ready & serial_last);
   assign busy           = active_reg;
`endif

   always_comb begin
      shift_next  = shift_reg;
      data_next   = data_reg;
      cnt_next    = cnt_reg;
      mode_next   = mode_reg;
      active_next = active_reg;
      load_en     = 1'b0;
      load_word   = parallel_data;
      load_msb    = msb_first;
`ifdef PARALLEL_TO_SERIAL_LANES_SKID_EN
      pend_full_next = pend_full_reg;
      pend_data_next = pend_data_reg;
      pend_msb_next  = pend_msb_reg;
`endif

      if (final_xfer) begin
`ifdef PARALLEL_TO_SERIAL_LANES_SKID_EN
         if (pend_full_reg) begin
            load_en        = 1'b1;
            load_word      = pend_data_reg;
            load_msb       = pend_msb_reg;
            pend_full_next = 1'b0;
         end else if (word_xfer) begin
            load_en = 1'b1;
         end else begin
            active_next = 1'b0;
         end
`else
         if (word_xfer) load_en = 1'b1;
         else           active_next = 1'b0;
`endif
      end else if (beat_xfer) begin
         data_next  = head(shift_reg, mode_reg);
         shift_next = tail(shift_reg, mode_reg);
         cnt_next   = cnt_reg + 1'b1;
      end

      if (word_xfer && !active_reg) load_en = 1'b1;

`ifdef PARALLEL_TO_SERIAL_LANES_SKID_EN
      // A word arriving mid-word is parked until the current word's final beat.
      if (word_xfer && active_reg && !final_xfer) begin
         pend_full_next = 1'b1;
         pend_data_next = parallel_data;
         pend_msb_next  = msb_first;
      end
`endif

      if (load_en) begin
         data_next   = head(load_word, load_msb);
         shift_next  = tail(load_word, load_msb);
         mode_next   = load_msb;
         cnt_next    = '0;
         active_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg  <= '0;
         data_reg   <= '0;
         cnt_reg    <= '0;
         mode_reg   <= 1'b0;
         active_reg <= 1'b0;
`ifdef PARALLEL_TO_SERIAL_LANES_SKID_EN
         pend_full_reg <= 1'b0;
         pend_data_reg <= '0;
         pend_msb_reg  <= 1'b0;
`endif
      end else begin
         shift_reg  <= shift_next;
         data_reg   <= data_next;
         cnt_reg    <= cnt_next;
         mode_reg   <= mode_next;
         active_reg <= active_next;
`ifdef PARALLEL_TO_SERIAL_LANES_SKID_EN
         pend_full_reg <= pend_full_next;
         pend_data_reg <= pend_data_next;
         pend_msb_reg  <= pend_msb_next;
`endif
      end
   end
endmodule
